// File: rtl/spawn_pos_sampler.sv
// Rejection-samples x/y LFSR words into on-screen spawn coordinates, clamping
// after a bounded number of rejected tries, and hands them out over valid/ready.
module spawn_pos_sampler #(
  parameter int X_MAX     = 640,
  parameter int Y_MAX     = 480,
  parameter int OBJ_W     = 32,
  parameter int OBJ_H     = 32,
  parameter int MAX_TRIES = 8
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       req,
  input  logic       ready,
  input  logic [9:0] lfsr_x,
  input  logic [8:0] lfsr_y,
  output logic       lfsr_en,
  output logic       valid,
  output logic [9:0] x_pos,
  output logic [8:0] y_pos,
  output logic       fallback,
  output logic       busy
);

  localparam logic [9:0] X_LIM = 10'(X_MAX - OBJ_W);
  localparam logic [8:0] Y_LIM = 9'(Y_MAX - OBJ_H);
  localparam int         CNT_W = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] try_cnt;
  logic             accept, last_try;
  logic             cnt_clr, cnt_inc, ld_acc, ld_fb;

  function automatic logic [9:0] sat_x(input logic [9:0] v);
    return (v > X_LIM) ? X_LIM : v;
  endfunction

  function automatic logic [8:0] sat_y(input logic [8:0] v);
    return (v > Y_LIM) ? Y_LIM : v;
  endfunction

  assign accept   = (lfsr_x <= X_LIM) && (lfsr_y <= Y_LIM);
  assign last_try = (int'(try_cnt) + 1) >= MAX_TRIES;

  // All outputs below are decoded from registered state only
  assign lfsr_en = (state == STEP);
  assign busy    = (state == STEP) || (state == CHECK);
  assign valid   = (state == DONE);

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    ld_acc    = 1'b0;
    ld_fb     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = STEP;
          cnt_clr   = 1'b1;
        end
      end
      STEP: state_nxt = CHECK;
      CHECK: begin
        if (accept) begin
          state_nxt = DONE;
          ld_acc    = 1'b1;
        end else if (last_try) begin
          state_nxt = DONE;
          ld_fb     = 1'b1;
        end else begin
          state_nxt = STEP;
          cnt_inc   = 1'b1;
        end
      end
      DONE: begin
        if (ready) begin
          if (req) begin
            state_nxt = STEP;
            cnt_clr   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      try_cnt  <= '0;
      x_pos    <= '0;
      y_pos    <= '0;
      fallback <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cnt_clr)
        try_cnt <= '0;
      else if (cnt_inc)
        try_cnt <= try_cnt + 1'b1;
      // Coordinates only move on completion so they never toggle while valid=0
      if (ld_acc) begin
        x_pos    <= lfsr_x;
        y_pos    <= lfsr_y;
        fallback <= 1'b0;
      end else if (ld_fb) begin
        x_pos    <= sat_x(lfsr_x);
        y_pos    <= sat_y(lfsr_y);
        fallback <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spawn_pos_sampler.sv
// Scoreboarded bench for spawn_pos_sampler: an upstream LFSR stand-in serves
// scripted candidate words, one per lfsr_en pulse.
module tb_spawn_pos_sampler;

  localparam int X_LIM     = 608;
  localparam int Y_LIM     = 448;
  localparam int MAX_TRIES = 8;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       req = 1'b0;
  logic       ready = 1'b0;
  logic [9:0] lfsr_x;
  logic [8:0] lfsr_y;
  logic       lfsr_en, valid, fallback, busy;
  logic [9:0] x_pos;
  logic [8:0] y_pos;

  always #5 clk = ~clk;

  spawn_pos_sampler dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .req      (req),
    .ready    (ready),
    .lfsr_x   (lfsr_x),
    .lfsr_y   (lfsr_y),
    .lfsr_en  (lfsr_en),
    .valid    (valid),
    .x_pos    (x_pos),
    .y_pos    (y_pos),
    .fallback (fallback),
    .busy     (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Candidate index advances once per lfsr_en pulse seen at a rising edge
  int         en_cnt = 0;
  int         base = 0;
  int         idx;
  logic [9:0] cx [12];
  logic [8:0] cy [12];

  always @(posedge clk) if (lfsr_en) en_cnt <= en_cnt + 1;

  assign idx    = ((en_cnt - base) > 11) ? 11 : (en_cnt - base);
  assign lfsr_x = cx[idx];
  assign lfsr_y = cy[idx];

  typedef struct {
    int x;
    int y;
    int fb;
    int pulses;
    int lat;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Load candidates 1, 2 and a fill value for 3.., then model the expected result
  task automatic push(input int x0, input int y0, input int x1, input int y1,
                      input int fx, input int fy);
    exp_t e;
    cx[0] = 10'd1023;
    cy[0] = 9'd511;
    cx[1] = 10'(x0);
    cy[1] = 9'(y0);
    cx[2] = 10'(x1);
    cy[2] = 9'(y1);
    for (int i = 3; i < 12; i++) begin
      cx[i] = 10'(fx);
      cy[i] = 9'(fy);
    end
    base     = en_cnt;
    e.fb     = 1;
    e.pulses = MAX_TRIES;
    e.lat    = 2 * MAX_TRIES;
    e.x      = (int'(cx[MAX_TRIES]) > X_LIM) ? X_LIM : int'(cx[MAX_TRIES]);
    e.y      = (int'(cy[MAX_TRIES]) > Y_LIM) ? Y_LIM : int'(cy[MAX_TRIES]);
    for (int i = 1; i <= MAX_TRIES; i++) begin
      if (int'(cx[i]) <= X_LIM && int'(cy[i]) <= Y_LIM) begin
        e.x      = int'(cx[i]);
        e.y      = int'(cy[i]);
        e.fb     = 0;
        e.pulses = i;
        e.lat    = 2 * i;
        break;
      end
    end
    sb.push_back(e);
  endtask

  task automatic start();
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  // Called just after the edge that launched the request
  task automatic wait_result(input string tag);
    int   lat = 0;
    exp_t e;
    @(negedge clk);
    while (!valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_valid"}, int'(valid), 1);
    e = sb.pop_front();
    check({tag, "_x"}, int'(x_pos), e.x);
    check({tag, "_y"}, int'(y_pos), e.y);
    check({tag, "_fb"}, int'(fallback), e.fb);
    check({tag, "_lat"}, lat, e.lat);
    check({tag, "_pulses"}, en_cnt - base, e.pulses);
  endtask

  task automatic take(input string tag);
    @(negedge clk);
    ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    check({tag, "_vdrop"}, int'(valid), 0);
  endtask

  initial begin
    int en0;
    for (int i = 0; i < 12; i++) begin
      cx[i] = '0;
      cy[i] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_en", int'(lfsr_en), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_x", int'(x_pos), 0);
    check("rst_y", int'(y_pos), 0);
    check("rst_fb", int'(fallback), 0);
    clr_n = 1'b1;
    repeat (2) @(negedge clk);

    push(608, 448, 0, 0, 0, 0);
    start();
    wait_result("bound");
    take("bound");

    push(609, 448, 0, 0, 0, 0);
    start();
    wait_result("xrej");
    take("xrej");

    push(608, 449, 5, 5, 5, 5);
    start();
    wait_result("yrej");
    take("yrej");

    push(700, 100, 300, 200, 300, 200);
    start();
    wait_result("onerej");
    take("onerej");

    push(1000, 500, 1000, 500, 1000, 500);
    start();
    wait_result("fallbk");
    take("fallbk");

    // Backpressure then back-to-back request
    push(1000, 100, 1000, 100, 1000, 100);
    start();
    wait_result("bp");
    en0 = en_cnt;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_valid", int'(valid), 1);
      check("bp_x", int'(x_pos), 608);
      check("bp_y", int'(y_pos), 100);
    end
    check("bp_noen", en_cnt, en0);
    push(12, 34, 12, 34, 12, 34);
    ready = 1'b1;
    req   = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    req   = 1'b0;
    check("b2b_vdrop", int'(valid), 0);
    check("b2b_en", int'(lfsr_en), 1);
    wait_result("b2b");
    take("b2b");

    // req pulses while busy must be ignored
    push(700, 100, 701, 100, 50, 60);
    start();
    fork
      wait_result("ign");
      repeat (3) begin
        @(negedge clk);
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
      end
    join
    take("ign");
    en0 = en_cnt;
    repeat (3) @(negedge clk);
    check("ign_idle_en", en_cnt, en0);
    check("ign_idle_valid", int'(valid), 0);

    // Asynchronous reset in the middle of CHECK
    push(700, 100, 700, 100, 700, 100);
    start();
    @(posedge clk);
    #1;
    check("mid_busy", int'(busy), 1);
    check("mid_en", int'(lfsr_en), 0);
    #1 clr_n = 1'b0;
    #1;
    check("arst_en", int'(lfsr_en), 0);
    check("arst_valid", int'(valid), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_x", int'(x_pos), 0);
    check("arst_y", int'(y_pos), 0);
    check("arst_fb", int'(fallback), 0);
    sb.delete();
    @(negedge clk);
    clr_n = 1'b1;
    en0 = en_cnt;
    repeat (10) begin
      @(negedge clk);
      check("idle_valid", int'(valid), 0);
    end
    check("idle_noen", en_cnt, en0);

    push(1, 2, 1, 2, 1, 2);
    start();
    wait_result("recov");
    take("recov");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spawn_pos_sampler.md
# spawn_pos_sampler

Converts the raw pseudo-random words from the x-axis and y-axis LFSRs into legal on-screen spawn coordinates for game objects. It sits directly downstream of the LFSRs and is the only block that drives their enable. On a request it advances the LFSRs and rejection-samples until the object fits inside the 640x480 visible area. If no candidate fits after a bounded number of tries, it clamps instead. The accepted coordinate is presented to the object manager via a valid/ready handshake.

## Interface
- X_MAX, 640, visible width in pixels
- Y_MAX, 480, visible height in pixels
- OBJ_W, 32, object width; legal x range is 0..X_MAX-OBJ_W (X_LIM = 608)
- OBJ_H, 32, object height; legal y range is 0..Y_MAX-OBJ_H (Y_LIM = 448)
- MAX_TRIES, 8, number of rejected samples before fallback (>= 1)
- clk  in  1  single system clock; all state changes on its rising edge
- clr_n  in  1  reset; asynchronous, active-low
- req  in  1  spawn request; sampled only in IDLE, or in DONE together with ready
- ready  in  1  consumer accepts the coordinate while valid = 1
- lfsr_x  in  10  current x LFSR state
- lfsr_y  in  9  current y LFSR state
- lfsr_en  out  1  advance both LFSRs; high for exactly one cycle per sample
- valid  out  1  x_pos/y_pos/fallback hold a completed sample
- x_pos  out  10  spawn x coordinate, 0..X_LIM
- y_pos  out  9  spawn y coordinate, 0..Y_LIM
- fallback  out  1  set when the coordinate was produced by clamping
- busy  out  1  high in STEP and CHECK

## Operation
- **States:** IDLE, STEP, CHECK, DONE.
- **Reset values:** state=IDLE, lfsr_en=0, valid=0, x_pos=0, y_pos=0, fallback=0, busy=0, try counter=0.
  - Reset mid-operation aborts immediately; lfsr_en drops asynchronously with the reset.
- **IDLE**
  - req=1 → STEP; clear the try counter.
  - req=0 → stay.
- **STEP**
  - lfsr_en=1, decoded from state only.
  - Always → CHECK.
- **CHECK** (lfsr_x/lfsr_y now hold the freshly advanced values)
  - accept = (lfsr_x <= X_LIM) && (lfsr_y <= Y_LIM); both compares unsigned and inclusive.
  - accept → DONE; register x_pos=lfsr_x, y_pos=lfsr_y, fallback=0.
  - reject with try counter+1 < MAX_TRIES → increment the counter; → STEP.
  - reject with try counter+1 == MAX_TRIES → DONE; register x_pos=min(lfsr_x, X_LIM), y_pos=min(lfsr_y, Y_LIM), fallback=1.
- **DONE**
  - valid=1; x_pos, y_pos and fallback are stable.
  - ready=0 → stay; outputs unchanged.
  - ready=1 and req=0 → IDLE; valid=0.
  - ready=1 and req=1 → STEP (back-to-back request); valid=0; clear the try counter.
- **Outside DONE**
  - x_pos, y_pos and fallback keep their last values; they are undefined-for-use while valid=0 but must not toggle.
  - ready is ignored.
  - req is ignored in STEP and CHECK; no queuing.
- lfsr_en is never asserted outside STEP. The LFSRs do not advance while idle, so the sequence is deterministic per request.
- An all-zero LFSR word is a legal coordinate (0,0) and is accepted; preventing LFSR lockup is the upstream block's job.

## Timing
- Let req be sampled at edge k in IDLE:
  - STEP occupies cycle k..k+1; lfsr_en is high in that cycle and the LFSRs advance at edge k+1.
  - CHECK is the cycle after edge k+1.
  - On accept, valid rises after edge k+2. Best-case latency is 2 cycles.
- Each reject adds 2 cycles. n rejects followed by an accept give valid after edge k+2+2n.
- Worst case (fallback): valid after edge k+2*MAX_TRIES (k+16 by default), with exactly MAX_TRIES lfsr_en pulses.
- Handshake completes on the edge where valid=1 and ready=1; valid is low the following cycle.
- Back-to-back: ready=req=1 at DONE edge j gives lfsr_en high in cycle j..j+1.
- busy = (state == STEP or CHECK), decoded from registered state; there is no combinational path from req or ready to any output.

## Test plan
- **Reset:** assert clr_n=0 mid-CHECK → all outputs go to their reset values without waiting for a clock. Release, req=0 for 10 cycles → lfsr_en never pulses and valid stays 0.
- **First-try accept and boundary:** req at edge k; in CHECK drive lfsr_x=608, lfsr_y=448 → valid after edge k+2 with x_pos=608, y_pos=448, fallback=0, exactly one lfsr_en pulse. Repeat with lfsr_x=609 → rejected.
- **One reject:** first CHECK sees lfsr_x=700, lfsr_y=100; second CHECK sees lfsr_x=300, lfsr_y=200 → valid after edge k+4 with x_pos=300, y_pos=200, two lfsr_en pulses.
- **Fallback:** hold lfsr_x=1000, lfsr_y=500 → 8 lfsr_en pulses, then valid after edge k+16 with x_pos=608, y_pos=448, fallback=1.
- **Backpressure and back-to-back:**
  - Hold ready=0 for 5 cycles in DONE → valid, x_pos and y_pos are stable, and lfsr_en stays 0.
  - Then drive ready=req=1 → valid drops and lfsr_en pulses in the next cycle.
  - req pulses during STEP/CHECK are ignored.
